logical_op_stage: RTL and testbench

LOGICAL_OP_STAGE -- requirements
Module: logical_op_stage

---
 rtl/logical_pkg.sv | 11 +
 rtl/logical_reduce_op.sv | 29 ++
 rtl/logical_op_stage.sv | 78 +++++++
 tb/tb_logical_op_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/logical_pkg.sv
// rtl/logical_pkg.sv - shared op encodings for the logical op stage
package logical_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

endpackage

// File: rtl/logical_reduce_op.sv
// rtl/logical_reduce_op.sv - or-reduce both operands, then combine per op
module logical_reduce_op
  import logical_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_e          op,
  output logic         c
);

  logic ra;
  logic rb;

  always_comb begin
    ra = |a;
    rb = |b;
    c  = 1'b0;
    unique case (op)
      OP_OR:   c = ra | rb;
      OP_AND:  c = ra & rb;
      OP_XOR:  c = ra ^ rb;
      OP_NOR:  c = ~(ra | rb);
      default: c = 1'b0;
    endcase
  end

endmodule

// File: rtl/logical_op_stage.sv
// rtl/logical_op_stage.sv - operand fifo feeding a registered logical-op result
module logical_op_stage
  import logical_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [N-1:0]  mem_a  [DEPTH];
  logic [N-1:0]  mem_b  [DEPTH];
  op_e           mem_op [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          head_c;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready = (level < FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (level != '0) && (!out_valid || out_ready);

  logical_reduce_op #(.N(N)) u_reduce (
    .a  (mem_a[rd_ptr]),
    .b  (mem_b[rd_ptr]),
    .op (mem_op[rd_ptr]),
    .c  (head_c)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= in_a;
      mem_b[wr_ptr]  <= in_b;
      mem_op[wr_ptr] <= op_e'(in_op);
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_c     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop) begin
        out_valid <= 1'b1;
        out_c     <= head_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logical_op_stage.sv
// tb/tb_logical_op_stage.sv - self-checking bench for logical_op_stage
module tb_logical_op_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic       out_c;
  logic [2:0] level;

  logical_op_stage #(.N(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       c;
  } vec_t;

  vec_t vecs [10];
  bit   q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   res_total = 0;
  int   acc_total = 0;
  int   first_res = 0;
  int   last_res = 0;

  function automatic bit ref_c(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit ra = (a != 0);
    bit rb = (b != 0);
    case (op)
      2'd0:    return ra || rb;
      2'd1:    return ra && rb;
      2'd2:    return ra != rb;
      default: return !(ra || rb);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_operands();
    in_a  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
    in_b  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
    in_op = 2'($urandom);
  endtask

  // out_valid && out_ready is about to complete at the next edge
  task automatic consume();
    if (q.size() == 0) begin
      check("extra_result", 32'(out_c), 32'hdead);
    end else begin
      check("result", 32'(out_c), 32'(q.pop_front()));
    end
    if (res_total == 0) first_res = cyc;
    last_res = cyc;
    res_total++;
  endtask

  task automatic traffic(input int cycles, input int pv, input int pr, input bit chk_lvl);
    bit stall;
    bit held;
    for (int k = 0; k < cycles; k++) begin
      out_ready = ($urandom_range(99) < pr);
      in_valid  = ($urandom_range(99) < pv);
      rand_operands();
      if (out_valid && out_ready) consume();
      if (in_valid && in_ready) begin
        q.push_back(ref_c(in_a, in_b, in_op));
        acc_total++;
      end
      stall = out_valid && !out_ready;
      held  = out_c;
      step();
      if (stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_c", 32'(out_c), 32'(held));
      end
      if (chk_lvl) check("stream_level_le1", 32'(level <= 3'd1), 32'd1);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64 && (q.size() > 0 || out_valid); k++) begin
      if (out_valid) consume();
      step();
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  acc;
    bit  seen;

    vecs[0] = '{8'h00, 8'h10, 2'b00, 1'b1};
    vecs[1] = '{8'h01, 8'h00, 2'b00, 1'b1};
    vecs[2] = '{8'h01, 8'h00, 2'b01, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 2'b10, 1'b1};
    vecs[4] = '{8'h01, 8'h00, 2'b11, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 2'b11, 1'b1};
    vecs[6] = '{8'h80, 8'hff, 2'b01, 1'b1};
    vecs[7] = '{8'hff, 8'h01, 2'b10, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 2'b00, 1'b0};
    vecs[9] = '{8'h00, 8'h40, 2'b11, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_op = 2'b00;
    step();
    step();
    check("reset_level", 32'(level), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_c", 32'(out_c), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // single pair through empty pipeline: out_valid two cycles after offer
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op;
      step();
      in_valid = 1'b0; in_a = 8'hff; in_b = 8'hff; in_op = 2'b01;
      check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_c", i), 32'(out_c), 32'(vecs[i].c));
      step();
      check($sformatf("vec%0d_retire", i), 32'(out_valid), 32'd0);
    end

    // fill under backpressure: 6 offered, 5 held
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      rand_operands();
      if (in_ready) begin
        q.push_back(ref_c(in_a, in_b, in_op));
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    check("fill_accepted", 32'(acc), 32'd5);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_level", 32'(level), 32'd4);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("fill_drain_valid", 32'(out_valid), 32'd1);
      consume();
      step();
    end
    check("fill_end_valid", 32'(out_valid), 32'd0);
    check("fill_end_level", 32'(level), 32'd0);

    // continuous streaming of 20 pairs
    res_total = 0; acc_total = 0;
    traffic(20, 100, 100, 1'b1);
    drain();
    check("stream_accepted", 32'(acc_total), 32'd20);
    check("stream_results", 32'(res_total), 32'd20);
    check("stream_back_to_back", 32'(last_res - first_res), 32'd19);

    // reset mid-operation with level 3 and a held result
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      rand_operands();
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_level", 32'(level), 32'd3);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_reset_level", 32'(level), 32'd0);
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check("no_stale_after_reset", 32'(seen), 32'd0);

    // random traffic with backpressure
    res_total = 0; acc_total = 0;
    traffic(400, 60, 50, 1'b0);
    drain();
    check("random_no_loss_dup", 32'(res_total), 32'(acc_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
